// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch controller sitting between the program counter
// and decode. It samples the PC, issues an instruction-memory read with a
// req/ack handshake, captures the returned word in the instruction register and
// presents it to decode with valid/ready. It also drives the PC's increment and
// load strobes (one-cycle INC after each accepted fetch, one-cycle load on a
// branch redirect).
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   defined   -> 8-bit wait counter; after MAX_WAIT ack-less cycles in WAIT or
//                DRAIN the read is dropped and FETCH_ERR is set (sticky until RE).
//   undefined -> waits forever for MEM_ACK, FETCH_ERR stays 0.
//
// Ports:
//   CLK        clock, rising edge
//   RE         synchronous active-high reset
//   PC_IN      current PC value
//   PC_INC     PC increment strobe
//   PC_LOAD    PC load strobe
//   PC_D       PC load value
//   MEM_ADDR   instruction memory address
//   MEM_RD     memory read request
//   MEM_DATA   memory read data (valid with MEM_ACK)
//   MEM_ACK    memory read acknowledge
//   IR_OUT     fetched instruction
//   IR_VALID   IR_OUT valid for decode
//   DEC_READY  decode accepts IR_OUT
//   BR_TAKEN   single-cycle redirect request
//   BR_TARGET  redirect address
//   HALT       stop issuing new fetches
//   FETCH_ERR  sticky fetch timeout flag
module fetch_unit #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic          CLK,
  input  logic          RE,
  input  logic [AW-1:0] PC_IN,
  output logic          PC_INC,
  output logic          PC_LOAD,
  output logic [AW-1:0] PC_D,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_RD,
  input  logic [DW-1:0] MEM_DATA,
  input  logic          MEM_ACK,
  output logic [DW-1:0] IR_OUT,
  output logic          IR_VALID,
  input  logic          DEC_READY,
  input  logic          BR_TAKEN,
  input  logic [AW-1:0] BR_TARGET,
  input  logic          HALT,
  output logic          FETCH_ERR
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, REDIR, DRAIN} state_t;

  state_t        state, state_nxt;
  logic          mem_rd_nxt, ir_valid_nxt, pc_inc_nxt, pc_load_nxt, err_nxt;
  logic [AW-1:0] mem_addr_nxt, pc_d_nxt;
  logic [DW-1:0] ir_out_nxt;
  logic          in_wait;
  logic          timeout;

  // A read is outstanding exactly in these two states.
  assign in_wait = (state == WAIT) || (state == DRAIN);

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Fires on the MAX_WAIT-th consecutive ack-less cycle since entering WAIT/DRAIN.
  assign timeout = in_wait && !MEM_ACK && (wait_cnt == 8'(MAX_WAIT - 1));

  always_ff @(posedge CLK) begin
    if (RE)                       wait_cnt <= '0;
    else if (state_nxt != state)  wait_cnt <= '0;  // any state entry restarts the count
    else if (in_wait && !MEM_ACK) wait_cnt <= wait_cnt + 8'd1;
  end
`else
  logic [7:0] unused_max_wait;
  assign unused_max_wait = 8'(MAX_WAIT);
  assign timeout         = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    mem_rd_nxt   = MEM_RD;
    mem_addr_nxt = MEM_ADDR;
    ir_out_nxt   = IR_OUT;
    ir_valid_nxt = IR_VALID;
    pc_inc_nxt   = 1'b0;
    pc_load_nxt  = 1'b0;
    pc_d_nxt     = PC_D;
    err_nxt      = FETCH_ERR;
    if (BR_TAKEN) begin
      // Redirect beats ack, decode-ready and halt; no increment on this edge.
      ir_valid_nxt = 1'b0;
      pc_load_nxt  = 1'b1;
      pc_d_nxt     = BR_TARGET;
      unique case (state)
        IDLE: state_nxt = IDLE;
        WAIT, DRAIN: begin
          if (MEM_ACK) begin
            // Read completes now but its data is dropped; REDIR gives the
            // load a cycle to land before the next REQ samples the PC.
            mem_rd_nxt = 1'b0;
            state_nxt  = REDIR;
          end else begin
            state_nxt  = DRAIN;
          end
        end
        default: state_nxt = REDIR;  // REQ, HOLD, REDIR (newest target wins)
      endcase
    end else begin
      unique case (state)
        IDLE: if (!HALT && !FETCH_ERR) state_nxt = REQ;
        REQ: begin
          mem_addr_nxt = PC_IN;
          mem_rd_nxt   = 1'b1;
          state_nxt    = WAIT;
        end
        WAIT: begin
          if (MEM_ACK) begin
            ir_out_nxt   = MEM_DATA;
            ir_valid_nxt = 1'b1;
            pc_inc_nxt   = 1'b1;
            mem_rd_nxt   = 1'b0;
            state_nxt    = HOLD;
          end
        end
        HOLD: begin
          if (DEC_READY) begin
            ir_valid_nxt = 1'b0;
            state_nxt    = HALT ? IDLE : REQ;
          end
        end
        REDIR: state_nxt = REQ;
        DRAIN: begin
          if (MEM_ACK) begin
            mem_rd_nxt = 1'b0;
            state_nxt  = REQ;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    // Timeout only while still parked in WAIT/DRAIN (not on WAIT->DRAIN entry).
    if (timeout && (state_nxt == state)) begin
      mem_rd_nxt = 1'b0;
      err_nxt    = 1'b1;
      state_nxt  = IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RE) begin
      state     <= IDLE;
      MEM_RD    <= 1'b0;
      MEM_ADDR  <= '0;
      IR_OUT    <= '0;
      IR_VALID  <= 1'b0;
      PC_INC    <= 1'b0;
      PC_LOAD   <= 1'b0;
      PC_D      <= '0;
      FETCH_ERR <= 1'b0;
    end else begin
      state     <= state_nxt;
      MEM_RD    <= mem_rd_nxt;
      MEM_ADDR  <= mem_addr_nxt;
      IR_OUT    <= ir_out_nxt;
      IR_VALID  <= ir_valid_nxt;
      PC_INC    <= pc_inc_nxt;
      PC_LOAD   <= pc_load_nxt;
      PC_D      <= pc_d_nxt;
      FETCH_ERR <= err_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized bench for fetch_unit. Includes a
// simple PC register and memory (data = hash of address) as environment, and a
// transaction-level expectation of addresses fetched and words delivered.
module tb_fetch_unit;
  localparam int MW = 4;

  logic        CLK = 1'b0;
  logic        RE, PC_INC, PC_LOAD, MEM_RD, MEM_ACK, IR_VALID;
  logic        DEC_READY, BR_TAKEN, HALT, FETCH_ERR;
  logic [15:0] PC_IN, PC_D, MEM_ADDR, MEM_DATA, IR_OUT, BR_TARGET;
  logic [15:0] pc;
  int          n_cmp = 0;
  int          n_fail = 0;

  fetch_unit #(.AW(16), .DW(16), .MAX_WAIT(MW)) dut (
    .CLK(CLK), .RE(RE), .PC_IN(PC_IN), .PC_INC(PC_INC), .PC_LOAD(PC_LOAD),
    .PC_D(PC_D), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD), .MEM_DATA(MEM_DATA),
    .MEM_ACK(MEM_ACK), .IR_OUT(IR_OUT), .IR_VALID(IR_VALID),
    .DEC_READY(DEC_READY), .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET),
    .HALT(HALT), .FETCH_ERR(FETCH_ERR)
  );

  always #5 CLK = ~CLK;

  // Program counter downstream of the strobes.
  always @(posedge CLK) begin
    if (RE)           pc <= 16'h0000;
    else if (PC_LOAD) pc <= PC_D;
    else if (PC_INC)  pc <= pc + 16'h0001;
  end
  assign PC_IN = pc;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    logic [15:0] exp_next, req_addr, got_addr, exp_d, tgt;
    bit          live, exp_irv, exp_inc, exp_load, rd_s, irv_s, br, ack, rdy, halt;
    int          w, n;

    RE = 1'b1; MEM_ACK = 1'b0; MEM_DATA = '0; DEC_READY = 1'b0;
    BR_TAKEN = 1'b0; BR_TARGET = '0; HALT = 1'b0;
    step(); step();
    chk("rst_rd", MEM_RD, 0);     chk("rst_addr", MEM_ADDR, 0);
    chk("rst_ir", IR_OUT, 0);     chk("rst_irv", IR_VALID, 0);
    chk("rst_inc", PC_INC, 0);    chk("rst_load", PC_LOAD, 0);
    chk("rst_pcd", PC_D, 0);      chk("rst_err", FETCH_ERR, 0);

    // Basic fetch from 0.
    RE = 1'b0; DEC_READY = 1'b1;
    step(); chk("b_req_rd", MEM_RD, 0);
    step(); chk("b_rd", MEM_RD, 1); chk("b_addr", MEM_ADDR, 16'h0000);
    MEM_ACK = 1'b1; MEM_DATA = 16'h1234;
    step(); chk("b_irv", IR_VALID, 1); chk("b_ir", IR_OUT, 16'h1234);
    chk("b_inc", PC_INC, 1); chk("b_rd0", MEM_RD, 0);
    MEM_ACK = 1'b0;
    step(); chk("b_irv0", IR_VALID, 0); chk("b_inc0", PC_INC, 0);
    step(); chk("b_rd2", MEM_RD, 1); chk("b_addr2", MEM_ADDR, 16'h0001);

    // Back-pressure.
    DEC_READY = 1'b0; MEM_ACK = 1'b1; MEM_DATA = 16'h5678;
    step(); chk("bp_irv", IR_VALID, 1); chk("bp_inc", PC_INC, 1);
    MEM_ACK = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_ir", IR_OUT, 16'h5678); chk("bp_irv_hold", IR_VALID, 1);
      chk("bp_rd", MEM_RD, 0);        chk("bp_inc0", PC_INC, 0);
    end
    DEC_READY = 1'b1;
    step(); chk("bp_rel", IR_VALID, 0);
    step(); chk("bp_addr", MEM_ADDR, 16'h0002); chk("bp_rd1", MEM_RD, 1);

    // Redirect during WAIT, late ack drained.
    BR_TAKEN = 1'b1; BR_TARGET = 16'h03E8;
    step(); chk("rw_load", PC_LOAD, 1); chk("rw_pcd", PC_D, 16'h03E8);
    chk("rw_rd", MEM_RD, 1); chk("rw_irv", IR_VALID, 0);
    BR_TAKEN = 1'b0;
    step(); chk("rw_load0", PC_LOAD, 0); chk("rw_rd_hold", MEM_RD, 1);
    MEM_ACK = 1'b1; MEM_DATA = 16'hDEAD;
    step(); chk("rw_drop_irv", IR_VALID, 0); chk("rw_rd0", MEM_RD, 0);
    chk("rw_inc0", PC_INC, 0);
    MEM_ACK = 1'b0;
    step(); chk("rw_addr", MEM_ADDR, 16'h03E8); chk("rw_irv2", IR_VALID, 0);

    // Ack and branch on the same edge.
    MEM_ACK = 1'b1; MEM_DATA = 16'hBEEF; BR_TAKEN = 1'b1; BR_TARGET = 16'h0100;
    step(); chk("ab_inc", PC_INC, 0); chk("ab_load", PC_LOAD, 1);
    chk("ab_pcd", PC_D, 16'h0100); chk("ab_irv", IR_VALID, 0); chk("ab_rd", MEM_RD, 0);
    MEM_ACK = 1'b0; BR_TAKEN = 1'b0;
    step(); chk("ab_irv2", IR_VALID, 0); chk("ab_load0", PC_LOAD, 0);
    step(); chk("ab_addr", MEM_ADDR, 16'h0100); chk("ab_rd1", MEM_RD, 1);

    // Reset mid-fetch with an ack during reset.
    RE = 1'b1; MEM_ACK = 1'b1; MEM_DATA = 16'hCAFE;
    step(); chk("rm_rd", MEM_RD, 0); chk("rm_addr", MEM_ADDR, 0); chk("rm_ir", IR_OUT, 0);
    chk("rm_irv", IR_VALID, 0); chk("rm_inc", PC_INC, 0); chk("rm_load", PC_LOAD, 0);
    chk("rm_pcd", PC_D, 0);
    step(); chk("rm_irv2", IR_VALID, 0);
    RE = 1'b0; HALT = 1'b1;
    step(); chk("rm_post_irv", IR_VALID, 0); chk("rm_post_rd", MEM_RD, 0);
    MEM_ACK = 1'b0;

    // Branch in IDLE while halted, then fetch across the address wrap.
    BR_TAKEN = 1'b1; BR_TARGET = 16'hFFFF;
    step(); chk("ib_load", PC_LOAD, 1); chk("ib_pcd", PC_D, 16'hFFFF); chk("ib_rd", MEM_RD, 0);
    BR_TAKEN = 1'b0; HALT = 1'b0;
    step(); chk("ib_load0", PC_LOAD, 0);
    step(); chk("wr_addr", MEM_ADDR, 16'hFFFF); chk("wr_rd", MEM_RD, 1);
    MEM_ACK = 1'b1; MEM_DATA = 16'h0F0F;
    step(); chk("wr_ir", IR_OUT, 16'h0F0F); chk("wr_inc", PC_INC, 1);
    MEM_ACK = 1'b0;
    step();
    step(); chk("wr_addr0", MEM_ADDR, 16'h0000); chk("wr_rd1", MEM_RD, 1);

    // Memory never answers.
`ifdef FETCH_TIMEOUT_EN
    n = 0;
    while (MEM_RD && n < 20) begin step(); n++; end
    chk("to_cycles", n, MW); chk("to_err", FETCH_ERR, 1); chk("to_rd", MEM_RD, 0);
    for (int i = 0; i < 6; i++) begin
      step(); chk("to_err_hold", FETCH_ERR, 1); chk("to_rd_hold", MEM_RD, 0);
    end
`else
    for (int i = 0; i < 20; i++) step();
    chk("nt_rd", MEM_RD, 1); chk("nt_err", FETCH_ERR, 0);
`endif
    RE = 1'b1;
    step(); step();
    chk("rst2_err", FETCH_ERR, 0); chk("rst2_rd", MEM_RD, 0);
    RE = 1'b0;

    // Randomized traffic against transaction-level expectations.
    exp_next = 16'h0000; req_addr = '0; got_addr = '0; exp_d = '0;
    live = 0; exp_irv = 0; w = 0;
    for (int c = 0; c < 1500; c++) begin
      rd_s  = MEM_RD;
      irv_s = IR_VALID;
      br    = ($urandom_range(0, 15) == 0);
      tgt   = 16'($urandom);
      if (rd_s) ack = (w >= 2) || ($urandom_range(0, 2) == 0);
      else      ack = ($urandom_range(0, 19) == 0);
      w     = (rd_s && !ack) ? w + 1 : 0;
      rdy   = ($urandom_range(0, 2) != 0);
      halt  = ($urandom_range(0, 9) == 0);
      BR_TAKEN = br; BR_TARGET = tgt; MEM_ACK = ack; MEM_DATA = memf(MEM_ADDR);
      DEC_READY = rdy; HALT = halt;
      step();
      exp_inc = 0; exp_load = 0;
      if (br) begin
        exp_load = 1; exp_d = tgt; exp_next = tgt; live = 0; exp_irv = 0;
      end else begin
        if (irv_s && rdy) exp_irv = 0;
        if (rd_s && ack && live) begin
          exp_irv = 1; exp_inc = 1; got_addr = req_addr;
          exp_next = req_addr + 16'h0001; live = 0;
        end
      end
      chk("r_inc", PC_INC, exp_inc);
      chk("r_load", PC_LOAD, exp_load);
      if (exp_load) chk("r_pcd", PC_D, exp_d);
      chk("r_irv", IR_VALID, exp_irv);
      if (exp_inc) chk("r_ir", IR_OUT, memf(got_addr));
      if (!rd_s && MEM_RD) begin
        chk("r_addr", MEM_ADDR, exp_next);
        req_addr = exp_next;
        live = 1;
      end
      chk("r_err", FETCH_ERR, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch controller directly downstream of the program counter.
- Samples the PC output and drives an instruction-memory read with a req/ack handshake. Captures the returned word into an instruction register and hands it to decode with a valid/ready handshake.
- Drives the PC's INC and L controls: a one-cycle INC pulse after each accepted fetch, a one-cycle load on branch redirect.

Parameters:
- AW, 16, address width; matches PC width.
- DW, 16, instruction width.
- MAX_WAIT, 15, wait-cycle limit before a fetch error; only used with FETCH_TIMEOUT_EN.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RE  in  1  reset, synchronous, active-high.
- PC_IN  in  AW  current PC value (PC OUT).
- PC_INC  out  1  PC increment strobe (PC INC).
- PC_LOAD  out  1  PC load strobe (PC L).
- PC_D  out  AW  PC load value (PC D).
- MEM_ADDR  out  AW  instruction memory address.
- MEM_RD  out  1  read request.
- MEM_DATA  in  DW  read data; valid when MEM_ACK=1.
- MEM_ACK  in  1  read acknowledge.
- IR_OUT  out  DW  fetched instruction.
- IR_VALID  out  1  IR_OUT valid for decode.
- DEC_READY  in  1  decode accepts IR_OUT.
- BR_TAKEN  in  1  redirect request, single-cycle.
- BR_TARGET  in  AW  redirect address.
- HALT  in  1  stop issuing new fetches.
- FETCH_ERR  out  1  sticky fetch timeout flag.

Behaviour:
- Clock is CLK. Reset is RE: synchronous and active-high, sampled only on the rising edge of CLK.
- RE=1 at a CLK edge:
  - state=IDLE.
  - MEM_RD, MEM_ADDR, IR_OUT, IR_VALID, PC_INC, PC_LOAD, PC_D, FETCH_ERR all 0.
  - RE dominates every other input, including mid-fetch.
  - MEM_ACK arriving after reset is ignored.
- All outputs are registered. PC_INC and PC_LOAD are never both 1.
- States: IDLE, REQ, WAIT, HOLD, REDIR, DRAIN.
- IDLE: HALT=0 -> REQ. MEM_ACK is ignored.
- REQ: one cycle. On exit edge: MEM_ADDR<=PC_IN, MEM_RD<=1 -> WAIT.
- WAIT: MEM_RD and MEM_ADDR are held stable until ACK.
  - MEM_ACK=1 at edge: IR_OUT<=MEM_DATA, IR_VALID<=1, PC_INC<=1 for one cycle, MEM_RD<=0 -> HOLD.
- HOLD: IR_OUT and IR_VALID are held until DEC_READY=1 at an edge.
  - On that edge: IR_VALID<=0; -> IDLE if HALT=1, else -> REQ.
  - The PC updates at the end of the first HOLD cycle, so the next REQ samples the incremented PC.
- Throughput: 3 cycles per instruction with zero-wait memory and DEC_READY=1.
- BR_TAKEN=1 at an edge has priority over ACK, DEC_READY and HALT:
  - IR_VALID<=0, PC_D<=BR_TARGET, PC_LOAD<=1 for one cycle. Any same-edge PC_INC is suppressed.
  - From WAIT: -> DRAIN. MEM_RD stays 1 until ACK; the data is discarded; then -> REQ.
  - From any other non-IDLE state: -> REDIR for one cycle, then -> REQ.
  - In IDLE: the load is still performed; state stays IDLE.
- BR_TAKEN in REDIR or DRAIN: PC_D and PC_LOAD are reissued with the new target. The newest target wins.
- ACK together with BR_TAKEN in WAIT: the data is dropped, no PC_INC, -> REDIR.
- Address wrap: the PC handles wrap; fetch from 0xFFFF followed by INC produces 0x0000.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to WAIT or DRAIN and increments each cycle without ACK.
  - When the count reaches MAX_WAIT: MEM_RD<=0, FETCH_ERR<=1 (sticky until RE), state -> IDLE.
  - While FETCH_ERR=1, IDLE does not leave; HALT is not required.
- Undefined: no counter; WAIT and DRAIN wait indefinitely; FETCH_ERR tied 0.

Test Plan:
- Reset then basic fetch.
  - Stimulus: RE=1 for 2 cycles, PC_IN=0x0000, MEM_ACK one cycle after MEM_RD rises with MEM_DATA=0x1234, DEC_READY=1.
  - Required: MEM_ADDR=0x0000, IR_OUT=0x1234, IR_VALID=1 for one cycle, exactly one PC_INC pulse, next MEM_ADDR=0x0001.
- Back-pressure.
  - Stimulus: DEC_READY=0 for 5 cycles after IR_VALID.
  - Required: IR_OUT stable, IR_VALID=1 throughout, MEM_RD=0, no second PC_INC.
- Redirect during WAIT.
  - Stimulus: BR_TAKEN=1 with BR_TARGET=0x03E8 while MEM_RD=1; ACK 2 cycles later with MEM_DATA=0xDEAD.
  - Required: PC_LOAD=1 with PC_D=0x03E8 for one cycle; 0xDEAD never appears on IR_VALID; next MEM_ADDR=0x03E8.
- ACK and BR_TAKEN on the same edge.
  - Required: no PC_INC, PC_LOAD=1, IR_VALID stays 0.
- Reset mid-fetch.
  - Stimulus: RE=1 while in WAIT; ACK arrives during reset.
  - Required: all outputs 0 next cycle, IR_VALID never set.
- FETCH_TIMEOUT_EN, MAX_WAIT=4, MEM_ACK held 0.
  - Required: MEM_RD drops after 4 WAIT cycles, FETCH_ERR=1 and held, MEM_RD never reasserts until RE.
